// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with a 2-entry skid buffer, flush and exception redirect; define PIPE_STALL_CNT_EN to add the stall_cnt output
module pipe_stage_reg #(
  parameter int INSTR_W = 32,
  parameter int PC_W = 32,
  parameter int EXC_W = 5,
  parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  input  logic               flush,
  input  logic               req,
`ifdef PIPE_STALL_CNT_EN
  output logic [15:0]        stall_cnt,
`endif
  output logic [1:0]         count
);
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [EXC_W-1:0]   exc;
    logic               bd;
  } entry_t;
  entry_t h_q, h_d, s_q, s_d, in_e;
  logic [1:0] count_q, count_d;
  logic in_ready_q, in_ready_d;
  logic acc, emt;
  assign in_e = '{instr: in_instr, pc: in_pc, exc: in_exc, bd: in_bd};
  assign acc = in_valid & in_ready_q;
  assign emt = out_valid & out_ready;
  assign out_valid = count_q != 2'd0;
  assign out_instr = out_valid ? h_q.instr : '0;
  assign out_exc = out_valid ? h_q.exc : '0;
  assign out_bd = out_valid & h_q.bd;
  assign out_pc = h_q.pc;
  assign in_ready = in_ready_q;
  assign count = count_q;
  // next head/skid/occupancy: req beats flush beats the handshake; bubble PC survives a flush
  always_comb begin
    h_d = h_q;
    s_d = s_q;
    count_d = count_q;
    if (req) begin
      count_d = 2'd0;
      h_d = '0;
      h_d.pc = HANDLER_PC;
      s_d = '0;
    end else if (flush) begin
      count_d = 2'd0;
      h_d = '0;
      h_d.pc = h_q.pc;
      s_d = '0;
    end else begin
      case (count_q)
        2'd0: if (acc) begin
          h_d = in_e;
          count_d = 2'd1;
        end
        2'd1: if (acc && emt) h_d = in_e;
          else if (acc) begin
            s_d = in_e;
            count_d = 2'd2;
          end else if (emt) count_d = 2'd0;
        default: if (emt) begin
          h_d = s_q;
          count_d = 2'd1;
        end
      endcase
    end
    in_ready_d = count_d != 2'd2;
  end
  // state registers; in_ready is registered off the next occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q <= '0;
      s_q <= '0;
      count_q <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      h_q <= h_d;
      s_q <= s_d;
      count_q <= count_d;
      in_ready_q <= in_ready_d;
    end
  end
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  assign stall_cnt = stall_q;
  // saturating count of cycles the head waits on downstream; flush leaves it alone
  always_comb begin
    stall_d = req ? 16'd0 : (out_valid && !out_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  // stall counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= 16'd0;
    else stall_q <= stall_d;
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, req = 1'b0, in_bd = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic [4:0] in_exc = '0;
  logic in_ready, out_valid, out_bd;
  logic [31:0] out_instr, out_pc;
  logic [4:0] out_exc;
  logic [1:0] count;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  exp_t q[$];
  int checks = 0, fails = 0;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_exc(out_exc), .out_bd(out_bd),
    .flush(flush), .req(req),
`ifdef PIPE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // monitor: every emitted head must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out: got pc=%0h instr=%0h, expected nothing", out_pc, out_instr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
        chk("out_pc", {32'd0, out_pc}, {32'd0, e.pc});
        chk("out_exc", {59'd0, out_exc}, {59'd0, e.exc});
        chk("out_bd", {63'd0, out_bd}, {63'd0, e.bd});
      end
    end
  end

  task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [4:0] x, input logic b);
    int n = 0;
    logic ok;
    in_valid = 1'b1;
    in_instr = i;
    in_pc = p;
    in_exc = x;
    in_bd = b;
    do begin
      @(negedge clk);
      ok = in_ready;
      if (ok) q.push_back('{instr: i, pc: p, exc: x, bd: b});
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL push_timeout: pc=%0h never accepted", p);
    end
    in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    cyc(1);
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_out_pc", 64'(out_pc), 64'd0);
    chk("post_rst_out_instr", 64'(out_instr), 64'd0);
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      push(32'(n + 1), 32'h3000 + 32'(4 * n), 5'd0, 1'b0);
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      chk("stream_out_pc", 64'(out_pc), 64'h3000 + 64'(4 * n));
    end
    cyc(2);
    chk("stream_drained_count", 64'(count), 64'd0);
    chk("stream_drained_q", 64'(q.size()), 64'd0);
    out_ready = 1'b0;
    push(32'h11, 32'h3000, 5'd0, 1'b0);
    push(32'h12, 32'h3004, 5'd0, 1'b0);
    chk("bp_count", 64'(count), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cyc(3);
    chk("bp_drained_q", 64'(q.size()), 64'd0);
    chk("bp_drained_count", 64'(count), 64'd0);
    out_ready = 1'b0;
    push(32'h21, 32'h3020, 5'd1, 1'b0);
    push(32'h22, 32'h3024, 5'd2, 1'b1);
    in_valid = 1'b1;
    in_instr = 32'h99;
    in_pc = 32'h3999;
    req = 1'b1;
    q.delete();
    cyc(1);
    req = 1'b0;
    in_valid = 1'b0;
    chk("req_count", 64'(count), 64'd0);
    chk("req_out_valid", 64'(out_valid), 64'd0);
    chk("req_out_pc", 64'(out_pc), 64'h4180);
    chk("req_out_instr", 64'(out_instr), 64'd0);
    chk("req_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cyc(3);
    chk("req_stays_empty", 64'(count), 64'd0);
    out_ready = 1'b0;
    push(32'h31, 32'h3010, 5'd3, 1'b1);
    chk("flush_pre_count", 64'(count), 64'd1);
    flush = 1'b1;
    q.delete();
    cyc(1);
    flush = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_exc", 64'(out_exc), 64'd0);
    chk("flush_out_bd", 64'(out_bd), 64'd0);
    chk("flush_out_pc", 64'(out_pc), 64'h3010);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    push(32'h32, 32'h3014, 5'd4, 1'b1);
    cyc(2);
    chk("flush_after_q", 64'(q.size()), 64'd0);
    out_ready = 1'b0;
    push(32'h51, 32'h3050, 5'd0, 1'b0);
    push(32'h52, 32'h3054, 5'd0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out_pc", 64'(out_pc), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    cyc(1);
    reset = 1'b1;
    out_ready = 1'b1;
    push(32'h61, 32'h3060, 5'd7, 1'b0);
    cyc(2);
    chk("resume_q", 64'(q.size()), 64'd0);
`ifdef PIPE_STALL_CNT_EN
    chk("stall_zero", 64'(stall_cnt), 64'd0);
    out_ready = 1'b0;
    push(32'h41, 32'h3040, 5'd0, 1'b0);
    cyc(10);
    chk("stall_10", 64'(stall_cnt), 64'd10);
    req = 1'b1;
    q.delete();
    cyc(1);
    req = 1'b0;
    chk("stall_req_clear", 64'(stall_cnt), 64'd0);
    push(32'h42, 32'h3044, 5'd0, 1'b0);
    cyc(65540);
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
    req = 1'b1;
    q.delete();
    cyc(1);
    req = 1'b0;
`endif
    chk("final_q_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
